// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline opcodes, ALU op codes and control bundle bit positions
package pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // Bit positions inside each bundle; id_ex and ex_mem slice with the same names.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } issue_state_t;

endpackage

// File: rtl/id_main_decoder.sv
// rtl/id_main_decoder.sv - combinational opcode decode into wb/m/ex control bundles
module id_main_decoder
    import pipe_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [WB_W-1:0] wb,
    output logic [M_W-1:0]  m,
    output logic [EX_W-1:0] ex,
    output logic            uses_rs2,
    output logic            illegal
);

    always_comb begin
        wb       = '0;
        m        = '0;
        ex       = '0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (instr[6:0])
            OP_R: begin
                wb[WB_REGWRITE]              = 1'b1;
                ex[EX_REGDST]                = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_R;
                uses_rs2                     = 1'b1;
            end
            OP_I_ALU: begin
                wb[WB_REGWRITE]              = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_I;
                ex[EX_ALUSRC]                = 1'b1;
            end
            OP_LOAD: begin
                wb[WB_REGWRITE]              = 1'b1;
                wb[WB_MEMTOREG]              = 1'b1;
                m[M_MEMREAD]                 = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex[EX_ALUSRC]                = 1'b1;
            end
            OP_STORE: begin
                m[M_MEMWRITE]                = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex[EX_ALUSRC]                = 1'b1;
                uses_rs2                     = 1'b1;
            end
            OP_BRANCH: begin
                m[M_BRANCH]                  = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_BR;
                uses_rs2                     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_issue_ctl.sv
// rtl/id_issue_ctl.sv - ID-stage issue control: decode, load-use stall, branch squash, perf counters
module id_issue_ctl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             if_id_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    output logic [WB_W-1:0]  ctlwb_out,
    output logic [M_W-1:0]   ctlm_out,
    output logic [EX_W-1:0]  ctlex_out,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             ex_flush,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    issue_state_t    state;
    logic [FW-1:0]   flush_left;
    logic [WB_W-1:0] dec_wb;
    logic [M_W-1:0]  dec_m;
    logic [EX_W-1:0] dec_ex;
    logic            dec_uses_rs2;
    logic            dec_illegal;
    logic            hz;
    logic            issue;
    logic            stall_inc;

    id_main_decoder u_dec (
        .instr    (instr),
        .wb       (dec_wb),
        .m        (dec_m),
        .ex       (dec_ex),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    // A bubble in IF/ID never stalls: it has no sources to protect.
    assign hz = if_id_valid && ex_memread && (ex_rd != 5'd0) &&
                ((ex_rd == instr[19:15]) || (dec_uses_rs2 && (ex_rd == instr[24:20])));

    assign stall_inc = (state == ST_RUN) && !branch_taken && hz;

    always_comb begin
        issue       = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        ex_flush    = 1'b0;
        if (branch_taken) begin
            if_id_flush = 1'b1;
            ex_flush    = 1'b1;
        end else if (state == ST_FLUSH) begin
            if_id_flush = 1'b1;
        end else if (state == ST_STALL) begin
            issue = if_id_valid;
        end else if (hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            issue = if_id_valid;
        end
    end

    assign ctlwb_out = issue ? dec_wb : '0;
    assign ctlm_out  = issue ? dec_m  : '0;
    assign ctlex_out = issue ? dec_ex : '0;
    assign illegal   = issue && dec_illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            flush_left <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            if (branch_taken) begin
                state      <= ST_FLUSH;
                flush_left <= FW'(FLUSH_CYCLES);
            end else begin
                case (state)
                    ST_RUN:   if (hz) state <= ST_STALL;
                    ST_STALL: state <= ST_RUN;
                    ST_FLUSH: begin
                        flush_left <= flush_left - FW'(1);
                        if (flush_left <= FW'(1)) state <= ST_RUN;
                    end
                    default:  state <= ST_RUN;
                endcase
            end
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_issue_ctl.sv
// tb/tb_id_issue_ctl.sv - randomized bench with a behavioural issue model plus directed literal checks
module tb_id_issue_ctl;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instr = 32'h0;
    logic          if_id_valid = 1'b0;
    logic          ex_memread = 1'b0;
    logic [4:0]    ex_rd = 5'd0;
    logic          branch_taken = 1'b0;
    logic [1:0]    ctlwb_out;
    logic [2:0]    ctlm_out;
    logic [3:0]    ctlex_out;
    logic          pc_write, if_id_write, if_id_flush, ex_flush, illegal;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    id_issue_ctl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .instr(instr), .if_id_valid(if_id_valid),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .ex_flush(ex_flush), .illegal(illegal), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = normal issue, 1 = one stall-release cycle pending, 2 = squashing with m_left bubbles.
    int m_mode = 0;
    int m_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [10:0] ref_decode(input logic [6:0] op);
        // {illegal, uses_rs2, wb[1:0], m[2:0], ex[3:0]}
        case (op)
            7'b0110011: return {1'b0, 1'b1, 2'b10, 3'b000, 4'b1100};
            7'b0010011: return {1'b0, 1'b0, 2'b10, 3'b000, 4'b0111};
            7'b0000011: return {1'b0, 1'b0, 2'b11, 3'b010, 4'b0001};
            7'b0100011: return {1'b0, 1'b1, 2'b00, 3'b001, 4'b0001};
            7'b1100011: return {1'b0, 1'b1, 2'b00, 3'b100, 4'b0010};
            default:    return {1'b1, 1'b0, 9'b0};
        endcase
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            logic [10:0] d;
            logic        use_dec, hzm;
            int          e_pw, e_iw, e_iff, e_exf;
            d = ref_decode(instr[6:0]);
            hzm = if_id_valid && ex_memread && ex_rd != 0 &&
                  (ex_rd == instr[19:15] || (d[9] && ex_rd == instr[24:20]));
            use_dec = 0; e_pw = 1; e_iw = 1; e_iff = 0; e_exf = 0;
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
            if (branch_taken) begin
                e_iff = 1; e_exf = 1;
                m_mode = 2; m_left = FC;
                if (m_flush < CMAX) m_flush++;
            end else if (m_mode == 2) begin
                e_iff = 1;
                m_left--;
                if (m_left == 0) m_mode = 0;
            end else if (m_mode == 1) begin
                use_dec = if_id_valid;
                m_mode = 0;
            end else if (hzm) begin
                e_pw = 0; e_iw = 0;
                m_mode = 1;
                if (m_stall < CMAX) m_stall++;
            end else begin
                use_dec = if_id_valid;
            end
            chk("ctlwb", ctlwb_out, use_dec ? d[8:7] : 0);
            chk("ctlm", ctlm_out, use_dec ? d[6:4] : 0);
            chk("ctlex", ctlex_out, use_dec ? d[3:0] : 0);
            chk("illegal", illegal, use_dec ? d[10] : 0);
            chk("pc_write", pc_write, e_pw);
            chk("if_id_write", if_id_write, e_iw);
            chk("if_id_flush", if_id_flush, e_iff);
            chk("ex_flush", ex_flush, e_exf);
        end
    end

    task automatic drive(input logic [31:0] i, input bit v, input bit mr,
                         input logic [4:0] rd, input bit bt);
        @(posedge clock); #1;
        instr = i; if_id_valid = v; ex_memread = mr; ex_rd = rd; branch_taken = bt;
        @(negedge clock); #1;
    endtask

    localparam logic [31:0] ADD_123 = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] ADD_RS5 = 32'h002281B3;  // add x3,x5,x2
    localparam logic [31:0] ADD_RS0 = 32'h002001B3;  // add x3,x0,x2
    localparam logic [31:0] ILL     = 32'h0000007F;

    initial begin
        logic [6:0] ops [6];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;

        #12;
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset flush_cnt", flush_cnt, 0);
        @(negedge clock); #2; reset = 1'b0;

        drive(ADD_123, 1, 0, 0, 0);
        chk("t1 wb", ctlwb_out, 2'b10);
        chk("t1 ex", ctlex_out, 4'b1100);
        chk("t1 pc_write", pc_write, 1);

        drive(ADD_RS5, 1, 1, 5, 0);
        chk("t2 c0 pc_write", pc_write, 0);
        chk("t2 c0 if_id_write", if_id_write, 0);
        chk("t2 c0 wb", ctlwb_out, 0);
        drive(ADD_RS5, 1, 1, 5, 0);
        chk("t2 stall_cnt", stall_cnt, 1);
        chk("t2 c1 pc_write", pc_write, 1);
        chk("t2 c1 wb", ctlwb_out, 2'b10);

        drive(ADD_RS0, 1, 1, 0, 0);
        chk("t3 pc_write", pc_write, 1);
        drive(ADD_123, 1, 0, 0, 0);
        chk("t3 stall_cnt", stall_cnt, 1);

        drive(ADD_123, 1, 0, 0, 1);
        chk("t4 ex_flush", ex_flush, 1);
        chk("t4 if_id_flush", if_id_flush, 1);
        for (int k = 0; k < FC; k++) begin
            drive(ADD_123, 1, 0, 0, 0);
            chk("t4 bubble iff", if_id_flush, 1);
            chk("t4 bubble exf", ex_flush, 0);
            chk("t4 bubble wb", ctlwb_out, 0);
        end
        drive(ADD_123, 1, 0, 0, 0);
        chk("t4 run iff", if_id_flush, 0);
        chk("t4 run wb", ctlwb_out, 2'b10);
        chk("t4 flush_cnt", flush_cnt, 1);

        drive(ADD_RS5, 1, 1, 5, 1);
        chk("t5 if_id_flush", if_id_flush, 1);
        chk("t5 pc_write", pc_write, 1);
        drive(ADD_RS5, 1, 1, 5, 0);
        chk("t5 stall_cnt", stall_cnt, 1);
        chk("t5 flush state", if_id_flush, 1);
        drive(ADD_123, 1, 0, 0, 0);

        drive(ILL, 1, 0, 0, 0);
        chk("t6 illegal", illegal, 1);
        chk("t6 ctl", {ctlwb_out, ctlm_out, ctlex_out}, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ri;
            ri = {$urandom_range(0, 127), 15'h0, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), ops[$urandom_range(0, 5)]};
            ri[24:20] = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            drive(ri, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), $urandom_range(0, 6) == 0);
        end

        for (int n = 0; n < 40; n++) drive(ADD_RS5, 1, 1, 5, 0);
        drive(ADD_123, 1, 0, 0, 0);
        chk("sat stall_cnt", stall_cnt, CMAX);

        drive(ADD_123, 1, 0, 0, 1);
        @(posedge clock); #1;
        branch_taken = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst flush_cnt", flush_cnt, 0);
        chk("rst iff", if_id_flush, 0);
        @(negedge clock); #2; reset = 1'b0;
        drive(ADD_123, 1, 0, 0, 0);
        chk("post rst wb", ctlwb_out, 2'b10);
        chk("post rst iff", if_id_flush, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
